// File: rtl/bus_arb_rr.sv
// Shared-bus interconnect: round-robin arbitration with bus locking, zero-idle
// handover between masters, address decode and a slave wait-state timeout.
`ifndef READ
`define READ 1'b0
`endif
`ifndef WRITE
`define WRITE 1'b1
`endif

module bus_arb_rr #(
   parameter int unsigned N_MASTERS  = 4,
   parameter int unsigned N_SLAVES   = 8,
   parameter int unsigned ADDR_WIDTH = 30,
   parameter int unsigned DATA_WIDTH = 32,
   parameter int unsigned TIMEOUT    = 16
) (
   input  logic                             clk,
   input  logic                             rst_,
   input  logic [N_MASTERS-1:0]             m_req,
   input  logic [N_MASTERS-1:0]             m_as,
   input  logic [N_MASTERS*ADDR_WIDTH-1:0]  m_addr,
   input  logic [N_MASTERS-1:0]             m_wr,
   input  logic [N_MASTERS*DATA_WIDTH-1:0]  m_wr_data,
   output logic [N_MASTERS-1:0]             m_grnt,
   output logic                             s_as,
   output logic [ADDR_WIDTH-1:0]            s_addr,
   output logic                             s_wr,
   output logic [DATA_WIDTH-1:0]            s_wr_data,
   output logic [N_SLAVES-1:0]              s_cs,
   input  logic [N_SLAVES-1:0]              s_rdy,
   input  logic [N_SLAVES*DATA_WIDTH-1:0]   s_out_data,
   output logic                             master_rdy,
   output logic [DATA_WIDTH-1:0]            master_data,
   output logic                             master_err
);
   localparam int unsigned MW = $clog2(N_MASTERS);
   localparam int unsigned SW = $clog2(N_SLAVES);
   localparam int unsigned CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

   typedef enum logic {IDLE = 1'b0, OWNED = 1'b1} state_t;

   state_t                state;
   logic [MW-1:0]         owner;
   logic [MW-1:0]         rr_ptr;
   logic [MW-1:0]         pick;
   logic [CW-1:0]         wait_cnt;
   logic [SW-1:0]         idx;
   logic                  release_c;
   logic                  any_req;
   logic                  sel_rdy;
   logic                  tmo_hit;
   logic [ADDR_WIDTH-1:0] addr_arr  [N_MASTERS];
   logic [DATA_WIDTH-1:0] wdata_arr [N_MASTERS];
   logic [DATA_WIDTH-1:0] rdata_arr [N_SLAVES];

   // Unpack the flat per-master and per-slave buses
   for (genvar i = 0; i < N_MASTERS; i++) begin : g_mst
      assign addr_arr[i]  = m_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
      assign wdata_arr[i] = m_wr_data[i*DATA_WIDTH +: DATA_WIDTH];
   end
   for (genvar j = 0; j < N_SLAVES; j++) begin : g_slv
      assign rdata_arr[j] = s_out_data[j*DATA_WIDTH +: DATA_WIDTH];
   end

   // First requester found scanning ptr, ptr+1, ... modulo N_MASTERS
   function automatic logic [MW-1:0] rr_pick(input logic [N_MASTERS-1:0] req,
                                             input logic [MW-1:0]        ptr);
      logic [MW-1:0] sel;
      logic          found;
      int unsigned   k;
      sel   = '0;
      found = 1'b0;
      for (int unsigned i = 0; i < N_MASTERS; i++) begin
         k = (32'(ptr) + i) % N_MASTERS;
         if (!found && req[MW'(k)]) begin
            sel   = MW'(k);
            found = 1'b1;
         end
      end
      return sel;
   endfunction

   assign any_req   = |m_req;
   assign release_c = (state == IDLE) || !m_req[owner];
   assign pick      = rr_pick(m_req, rr_ptr);

   // Owner's request path onto the shared bus
   always_comb begin
      s_as      = 1'b0;
      s_addr    = '0;
      s_wr      = `READ;
      s_wr_data = '0;
      if (state == OWNED) begin
         s_as      = m_as[owner];
         s_addr    = addr_arr[owner];
         s_wr      = m_wr[owner];
         s_wr_data = wdata_arr[owner];
      end
   end

   assign idx         = s_addr[ADDR_WIDTH-1 -: SW];
   assign s_cs        = s_as ? (N_SLAVES'(1) << idx) : '0;
   assign sel_rdy     = s_as & s_rdy[idx];
   // A ready slave on the timeout cycle still completes normally
   assign tmo_hit     = (TIMEOUT != 0) && s_as && !s_rdy[idx] && (wait_cnt == CW'(TIMEOUT));
   assign master_rdy  = sel_rdy | tmo_hit;
   assign master_err  = tmo_hit;
   assign master_data = sel_rdy ? rdata_arr[idx] : '0;

   // Arbitration state, grant and wait-state counter
   always_ff @(posedge clk or negedge rst_) begin
      if (!rst_) begin
         state    <= IDLE;
         owner    <= '0;
         rr_ptr   <= '0;
         m_grnt   <= '0;
         wait_cnt <= '0;
      end else begin
         if (release_c) begin
            if (any_req) begin
               state  <= OWNED;
               owner  <= pick;
               rr_ptr <= MW'((32'(pick) + 32'd1) % N_MASTERS);
               m_grnt <= N_MASTERS'(1) << pick;
            end else begin
               state  <= IDLE;
               m_grnt <= '0;
            end
         end
         if ((TIMEOUT == 0) || release_c || master_rdy || !s_as) begin
            wait_cnt <= '0;
         end else begin
            wait_cnt <= wait_cnt + CW'(1);
         end
      end
   end

endmodule

// File: doc/bus_arb_rr.md
Name: bus_arb_rr

Overview:
Parametrised shared-bus interconnect: N_MASTERS masters, N_SLAVES slaves, one shared address/data path. It adds three things to the existing fixed 4x8 bus:
- Fair round-robin arbitration, with the grant held for as long as the owner keeps requesting (bus locking).
- Zero-idle-cycle handover between masters.
- A wait-state timeout that terminates hung slave accesses with an error flag.

It sits between the CPU/DMA masters and the memory/peripheral slaves, in place of the fixed 4x8 bus.

Parameters:
N_MASTERS, 4, number of masters; >=2.
N_SLAVES, 8, number of slaves; power of two, >=2.
ADDR_WIDTH, 30, word address width.
DATA_WIDTH, 32, data width.
TIMEOUT, 16, maximum wait cycles before forced termination; 0 disables the timeout.

Ports:
clk  in  1  clock; all state updates on rising edge.
rst_  in  1  asynchronous active-low reset.
m_req  in  N_MASTERS  bus request, bit i = master i.
m_as  in  N_MASTERS  address strobe per master.
m_addr  in  N_MASTERS*ADDR_WIDTH  packed addresses; master i at slice [i*ADDR_WIDTH +: ADDR_WIDTH].
m_wr  in  N_MASTERS  read/write per master, encoded with the codebase `READ`/`WRITE` defines.
m_wr_data  in  N_MASTERS*DATA_WIDTH  packed write data.
m_grnt  out  N_MASTERS  one-hot (or zero) registered grant.
s_as  out  1  strobe of the owning master.
s_addr  out  ADDR_WIDTH  address of the owning master.
s_wr  out  1  read/write of the owning master.
s_wr_data  out  DATA_WIDTH  write data of the owning master.
s_cs  out  N_SLAVES  one-hot slave select.
s_rdy  in  N_SLAVES  per-slave ready.
s_out_data  in  N_SLAVES*DATA_WIDTH  packed slave read data.
master_rdy  out  1  transfer complete (normal or timeout).
master_data  out  DATA_WIDTH  read data returned to the owner.
master_err  out  1  transfer terminated by timeout.

Behaviour:
- Reset (async, immediate, including mid-transfer):
  - state=IDLE, m_grnt=0, rr_ptr=0, wait_cnt=0.
  - All bus-side outputs forced to 0; s_wr=`READ`.
  - master_rdy=0, master_err=0, master_data=0.
- States: IDLE (no owner), OWNED (owner index registered).
- IDLE:
  - If m_req!=0 at an edge: owner <= first requester scanning rr_ptr, rr_ptr+1, ... (mod N_MASTERS).
  - Then m_grnt <= onehot(owner), rr_ptr <= (owner+1) mod N_MASTERS, state <= OWNED.
  - Grant becomes visible one cycle after the request is first sampled.
- OWNED, m_req[owner]=1: grant held; all other requests ignored.
- OWNED, m_req[owner]=0 at an edge:
  - If other requests are pending: direct handover at that same edge to the next requester in round-robin order. rr_ptr updates as above; no IDLE cycle.
  - Otherwise: state <= IDLE, m_grnt <= 0.
- Bus mux (combinational from the registered owner):
  - In OWNED, s_as/s_addr/s_wr/s_wr_data equal the owner's slices.
  - In IDLE they are all 0 and s_wr=`READ`.
- Decode:
  - idx = s_addr[ADDR_WIDTH-1 -: log2(N_SLAVES)].
  - s_cs = onehot(idx) when s_as=1, else 0.
- Response (combinational):
  - Normal: when s_as=1 and s_rdy[idx]=1, master_rdy=1, master_err=0, master_data = s_out_data slice idx.
  - Otherwise master_rdy=0 and master_data=0, unless a timeout fires.
- Timeout (TIMEOUT>0):
  - wait_cnt increments each cycle with s_as=1 and s_rdy[idx]=0.
  - wait_cnt clears on: master_rdy, s_as=0, any owner change.
  - When wait_cnt==TIMEOUT and s_rdy[idx]=0, that cycle drives master_rdy=1, master_err=1, master_data=0. wait_cnt clears at the next edge.
  - Counter width is clog2(TIMEOUT+1); no wrap is possible.
- Timeout (TIMEOUT=0): wait_cnt held at 0; master_err is constant 0.
- Simultaneous events:
  - Slave ready in the same cycle the owner drops m_req: the transfer completes normally in that cycle; handover happens at the edge.
  - s_rdy arriving exactly at wait_cnt==TIMEOUT: the normal completion wins (master_err=0).
- Single requester: re-granted after its own release, provided it requests again. Its 1-cycle gap is only the IDLE cycle.

Test Plan:
- Reset/idle: rst_=0 with random inputs -> all outputs 0. Release with m_req=0 -> m_grnt stays 4'b0000, s_cs=0.
- Round-robin fairness: m_req=4'b1110 held, each owner drops req for one cycle after 2 cycles -> grant order 1,2,3,1. Master 0 is never granted. No IDLE cycle between grants.
- Decode/read: master 2 owns, m_addr slice=30'h1000_0000, m_as=1, s_rdy=8'hFF, s_out_data slice k = k -> s_cs=8'b0000_0100, master_rdy=1, master_data=2.
- Decode top slave: addr 30'h3800_0000 -> s_cs=8'b1000_0000, master_data=7. Write with m_wr=`WRITE`, data 32'hDEADBEEF -> s_wr=`WRITE`, s_wr_data=32'hDEADBEEF.
- Timeout: TIMEOUT=16, slave 5 rdy=0, s_as held -> master_rdy=0 for 16 cycles, then exactly one cycle master_rdy=1, master_err=1, master_data=0. Counter restarts and it repeats. Same case with rdy asserted on cycle 17 -> master_err=0.
- Mid-transfer reset: master 3 owns with wait_cnt=5 -> pulse rst_=0 asynchronously between edges. m_grnt=0 immediately; after release, arbitration restarts at rr_ptr=0 (m_req=4'b1001 grants master 0).
